// File: rtl/fifo_packer.sv
// fifo_packer: reads DW-bit words from a FIFO and pairs them into one
// 2*DW-bit packed word (first word in the low half). A lone word still held
// after FLUSH_CYC idle cycles is sent alone with pk_part set. Every output
// comes straight from a register.
module fifo_packer #(
    parameter int DW        = 3,
    parameter int FLUSH_CYC = 8     // legal range 1..255
) (
    input  logic            rclk,
    input  logic            rst,
    input  logic            empy,
    input  logic [DW-1:0]   datout,
    output logic            rd,
    output logic [2*DW-1:0] pk_data,
    output logic            pk_valid,
    output logic            pk_part,
    input  logic            pk_ready,
    output logic [7:0]      wcnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        HOLD,
        SEND
    } state_t;

    // Timer value on which a lone held word is flushed.
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 1);

    state_t          state_q, state_d;
    logic            slot_q, slot_d;        // 0 = next word goes low, 1 = high
    logic [7:0]      timer_q, timer_d;
    logic [2*DW-1:0] pk_data_q, pk_data_d;
    logic            pk_part_q, pk_part_d;
    logic            rd_q;
    logic            pk_valid_q;
    logic [7:0]      wcnt_q;

    // Next-state decode plus slot, flush timer and packed-word updates.
    always_comb begin
        // NOTE: every signal takes its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        slot_d    = slot_q;
        timer_d   = timer_q;
        pk_data_d = pk_data_q;
        pk_part_d = pk_part_q;

        unique case (state_q)
            IDLE: begin
                if (!empy) state_d = RD;
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (!slot_q) begin
                    pk_data_d[DW-1:0] = datout;
                    slot_d            = 1'b1;
                    timer_d           = '0;
                    state_d           = empy ? HOLD : RD;
                end else begin
                    pk_data_d[2*DW-1:DW] = datout;
                    pk_part_d            = 1'b0;
                    state_d              = SEND;
                end
            end
            HOLD: begin
                // A newly arrived word beats the flush, even on the timeout cycle.
                if (!empy) begin
                    state_d = RD;
                end else if (timer_q == FLUSH_LAST) begin
                    pk_data_d[2*DW-1:DW] = '0;
                    pk_part_d            = 1'b1;
                    state_d              = SEND;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            SEND: begin
                if (pk_ready) begin
                    slot_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered outputs; rst overrides everything.
    always_ff @(posedge rclk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= 1'b0;
            timer_q    <= '0;
            pk_data_q  <= '0;
            pk_part_q  <= 1'b0;
            rd_q       <= 1'b0;
            pk_valid_q <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            timer_q    <= timer_d;
            pk_data_q  <= pk_data_d;
            pk_part_q  <= pk_part_d;
            rd_q       <= (state_d == RD);
            pk_valid_q <= (state_d == SEND);
            if (state_d == RD) wcnt_q <= wcnt_q + 8'd1;
        end
    end

    assign rd       = rd_q;
    assign pk_data  = pk_data_q;
    assign pk_valid = pk_valid_q;
    assign pk_part  = pk_part_q;
    assign wcnt     = wcnt_q;

endmodule

// File: tb/tb_fifo_packer.sv
// Testbench for fifo_packer: a cycle table for the basic pair and flush
// timing, hand-written corner sequences, and randomized streams checked
// against an in-order word scoreboard fed by a queue-based FIFO model.
module tb_fifo_packer;

    localparam int DW = 3;
    localparam int FC = 8;

    logic            rclk     = 1'b0;
    logic            rst      = 1'b1;
    logic            empy     = 1'b1;
    logic [DW-1:0]   datout   = '0;
    logic            pk_ready = 1'b0;
    logic            rd;
    logic [2*DW-1:0] pk_data;
    logic            pk_valid;
    logic            pk_part;
    logic [7:0]      wcnt;

    int total = 0;
    int bad   = 0;

    always #5 rclk = ~rclk;

    fifo_packer #(.DW(DW), .FLUSH_CYC(FC)) dut (
        .rclk    (rclk),
        .rst     (rst),
        .empy    (empy),
        .datout  (datout),
        .rd      (rd),
        .pk_data (pk_data),
        .pk_valid(pk_valid),
        .pk_part (pk_part),
        .pk_ready(pk_ready),
        .wcnt    (wcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    // ---------------- FIFO model (queue), active when fifo_en=1 ----------------
    logic [DW-1:0] fq[$];
    bit            fifo_en  = 1'b0;
    logic          rd_seen  = 1'b0;
    logic          rst_seen = 1'b0;

    always @(negedge rclk) begin
        rd_seen  = rd;
        rst_seen = rst;
    end

    // A rd seen during a cycle pops one word, presented on datout the next cycle.
    always @(posedge rclk) begin
        #1;
        if (fifo_en) begin
            if (rd_seen) begin
                if (!rst_seen) check("fifo_nonempty_at_rd", 32'(fq.size() != 0), 32'd1);
                if (fq.size() != 0) datout = fq.pop_front();
            end
            empy = (fq.size() == 0);
        end
    end

    // ---------------- scoreboard and protocol monitor ----------------
    bit              sb_en        = 1'b0;
    bit              sb_full_only = 1'b0;
    logic [DW-1:0]   exp_q[$];
    int              pk_cnt       = 0;
    logic            prev_hold    = 1'b0;
    logic [2*DW-1:0] prev_data    = '0;
    logic            prev_part    = 1'b0;

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        empy = 1'b0;
        if (sb_en) exp_q.push_back(w);
    endtask

    always @(negedge rclk) begin
        if (!rst) begin
            if (pk_valid) check("no_rd_in_send", 32'(rd), 32'd0);
            if (prev_hold) begin
                check("hold_valid", 32'(pk_valid), 32'd1);
                check("hold_data", 32'(pk_data), 32'(prev_data));
                check("hold_part", 32'(pk_part), 32'(prev_part));
            end
            if (sb_en && pk_valid && pk_ready) begin
                pk_cnt++;
                check("sb_have_low", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("sb_low", 32'(pk_data[DW-1:0]), 32'(exp_q.pop_front()));
                if (pk_part) begin
                    check("sb_upper_zero", 32'(pk_data[2*DW-1:DW]), 32'd0);
                end else begin
                    check("sb_have_high", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("sb_high", 32'(pk_data[2*DW-1:DW]), 32'(exp_q.pop_front()));
                end
                if (sb_full_only) check("sb_full_pair", 32'(pk_part), 32'd0);
            end
        end
        prev_hold = pk_valid && !pk_ready && !rst;
        prev_data = pk_data;
        prev_part = pk_part;
    end

    task automatic do_reset();
        rst      = 1'b1;
        sb_en    = 1'b0;
        pk_ready = 1'b0;
        fq.delete();
        exp_q.delete();
        empy     = 1'b1;
        datout   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget && !pk_valid; i++) tick();
        check(name, 32'(pk_valid), 32'd1);
    endtask

    task automatic wait_rd(input string name, input int budget);
        for (int i = 0; i < budget && !rd; i++) tick();
        check(name, 32'(rd), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"}, 32'(rd), 32'd0);
        check({tag, "_valid"}, 32'(pk_valid), 32'd0);
        check({tag, "_part"}, 32'(pk_part), 32'd0);
        check({tag, "_data"}, 32'(pk_data), 32'd0);
        check({tag, "_wcnt"}, 32'(wcnt), 32'd0);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic            rst;
        logic            empy;
        logic [DW-1:0]   dat;
        logic            rdy;
        logic            e_rd;
        logic            e_valid;
        logic            e_part;
        logic [2*DW-1:0] e_data;
        logic [7:0]      e_wcnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic e, input logic [DW-1:0] d, input logic k,
                       input logic xrd, input logic xv, input logic xp,
                       input logic [2*DW-1:0] xd, input logic [7:0] xw);
        vec_t v;
        v = '{rst: r, empy: e, dat: d, rdy: k, e_rd: xrd, e_valid: xv, e_part: xp, e_data: xd, e_wcnt: xw};
        tv.push_back(v);
    endtask

    logic [DW-1:0] w[8];
    int            pushes;

    initial begin
        // Reset state.
        tick();
        tick();
        check_zero("reset");

        // Row: inputs for this cycle, outputs expected during this cycle.
        // Pair 5 then 2; pk_ready=1 outside SEND must be ignored.
        add(0, 0, 0, 1,  0, 0, 0, 6'o00, 8'd0);   // IDLE
        add(0, 0, 0, 1,  1, 0, 0, 6'o00, 8'd1);   // RD
        add(0, 0, 5, 1,  0, 0, 0, 6'o00, 8'd1);   // CAP low
        add(0, 0, 0, 1,  1, 0, 0, 6'o00, 8'd2);   // RD
        add(0, 1, 2, 1,  0, 0, 0, 6'o00, 8'd2);   // CAP high
        add(0, 1, 0, 1,  0, 1, 0, 6'b010_101, 8'd2); // SEND, accepted
        add(0, 1, 0, 0,  0, 0, 0, 6'o00, 8'd2);   // IDLE
        add(0, 1, 0, 1,  0, 0, 0, 6'o00, 8'd2);
        // Lone word 7, FIFO stays empty: flush after 8 HOLD cycles.
        add(0, 0, 0, 1,  0, 0, 0, 6'o00, 8'd2);   // IDLE
        add(0, 0, 0, 1,  1, 0, 0, 6'o00, 8'd3);   // RD
        add(0, 1, 7, 1,  0, 0, 0, 6'o00, 8'd3);   // CAP low -> HOLD
        for (int i = 0; i < FC; i++)
            add(0, 1, 0, 1, 0, 0, 0, 6'o00, 8'd3); // HOLD timer 0..7
        add(0, 1, 0, 0,  0, 1, 1, 6'b000_111, 8'd3); // SEND partial, stalled
        add(0, 1, 0, 1,  0, 1, 1, 6'b000_111, 8'd3); // accepted
        add(0, 1, 0, 0,  0, 0, 0, 6'o00, 8'd3);   // IDLE
        // Reset beats a non-empty FIFO in IDLE.
        add(1, 0, 0, 0,  0, 0, 0, 6'o00, 8'd3);
        add(0, 1, 0, 0,  0, 0, 0, 6'o00, 8'd0);

        for (int i = 0; i < tv.size(); i++) begin
            tick();
            rst      = tv[i].rst;
            empy     = tv[i].empy;
            datout   = tv[i].dat;
            pk_ready = tv[i].rdy;
            check($sformatf("tv%0d_rd", i), 32'(rd), 32'(tv[i].e_rd));
            check($sformatf("tv%0d_valid", i), 32'(pk_valid), 32'(tv[i].e_valid));
            check($sformatf("tv%0d_wcnt", i), 32'(wcnt), 32'(tv[i].e_wcnt));
            if (tv[i].e_valid) begin
                check($sformatf("tv%0d_data", i), 32'(pk_data), 32'(tv[i].e_data));
                check($sformatf("tv%0d_part", i), 32'(pk_part), 32'(tv[i].e_part));
            end
        end

        fifo_en = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = DW'($urandom);

        // Second word arrives on the flush-timeout cycle: read wins.
        do_reset();
        pk_ready = 1'b1;
        push(w[0]);
        wait_rd("r32_first_rd", 20);
        repeat (9) tick();                        // CAP, then HOLD timer 0..7
        check("r32_no_flush_yet", 32'(pk_valid), 32'd0);
        push(w[1]);
        tick();
        check("r32_rd_wins", 32'(rd), 32'd1);
        check("r32_no_partial", 32'(pk_valid), 32'd0);
        wait_valid("r32_valid", 20);
        check("r32_data", 32'(pk_data), 32'({w[1], w[0]}));
        check("r32_part", 32'(pk_part), 32'd0);

        // Backpressure: SEND stalled for 10 more cycles.
        do_reset();
        for (int i = 0; i < 4; i++) push(w[i]);
        wait_valid("r33_valid", 30);
        check("r33_data", 32'(pk_data), 32'({w[1], w[0]}));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("r33_hold_valid", 32'(pk_valid), 32'd1);
            check("r33_hold_data", 32'(pk_data), 32'({w[1], w[0]}));
            check("r33_hold_no_rd", 32'(rd), 32'd0);
        end
        pk_ready = 1'b1;
        tick();
        check("r33_drop", 32'(pk_valid), 32'd0);
        wait_valid("r33_valid2", 30);
        check("r33_data2", 32'(pk_data), 32'({w[3], w[2]}));
        check("r33_wcnt", 32'(wcnt), 32'd4);

        // Reset while rd is high: the word in flight is discarded.
        do_reset();
        pk_ready = 1'b1;
        push(w[0]);
        push(w[1]);
        push(w[2]);
        wait_rd("r34_rd", 20);
        rst = 1'b1;
        tick();
        check_zero("r34_rd_reset");
        rst = 1'b0;
        wait_valid("r34_valid", 30);
        check("r34_data", 32'(pk_data), 32'({w[2], w[1]}));
        check("r34_wcnt", 32'(wcnt), 32'd2);
        tick();
        // Reset mid-SEND.
        pk_ready = 1'b0;
        push(w[3]);
        push(w[4]);
        wait_valid("r34_valid2", 30);
        rst = 1'b1;
        tick();
        check_zero("r34_send_reset");
        rst      = 1'b0;
        pk_ready = 1'b1;
        push(w[5]);
        push(w[6]);
        wait_valid("r34_valid3", 30);
        check("r34_data3", 32'(pk_data), 32'({w[6], w[5]}));
        check("r34_part3", 32'(pk_part), 32'd0);

        // 300 preloaded words, random pk_ready: 150 full pairs, wcnt wraps to 44.
        do_reset();
        sb_en        = 1'b1;
        sb_full_only = 1'b1;
        pk_cnt       = 0;
        for (int i = 0; i < 300; i++) push(DW'($urandom));
        for (int i = 0; i < 6000 && pk_cnt < 150; i++) begin
            pk_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("r35_packets", 32'(pk_cnt), 32'd150);
        check("r35_words_left", 32'(exp_q.size()), 32'd0);
        check("r35_wcnt", 32'(wcnt), 32'd44);
        tick();
        tick();
        check("r35_no_extra", 32'(pk_cnt), 32'd150);

        // Sparse random arrivals: partial flushes mixed with full pairs.
        do_reset();
        sb_en        = 1'b1;
        sb_full_only = 1'b0;
        pushes       = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if ($urandom_range(0, 9) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) push(DW'($urandom));
                pushes += n;
            end
            pk_ready = ($urandom_range(0, 3) != 0);
        end
        pk_ready = 1'b1;
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_wcnt", 32'(wcnt), 32'(pushes % 256));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
